// File: rtl/coin_feeder_20.sv
// Coin feeder: queues 5/10-cent coin pulses and forwards them one at a time to a
// vending machine. It also tracks the credit forwarded, the bottles dispensed and the change returned.
module coin_feeder_20 #(
  parameter int DEPTH = 4,
  parameter int PRICE = 20
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       coin_5,
  input  logic       coin_10,
  input  logic       bottle,
  input  logic [1:0] change,
  output logic [1:0] in,
  output logic       full,
  output logic       reject,
  output logic [5:0] credit,
  output logic [7:0] bottle_count,
  output logic [7:0] change_total
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  if (DEPTH < 2 || DEPTH > 16 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("coin_feeder_20: DEPTH must be a power of two in 2..16");
  end
  if (PRICE < 5 || (PRICE % 5) != 0) begin : g_bad_price
    $error("coin_feeder_20: PRICE must be a positive multiple of 5");
  end

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_GAP} state_t;

  logic [1:0]    mem_q [DEPTH];
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  state_t        state_q, state_d;
  logic [1:0]    in_q, in_d;
  logic          reject_q, reject_d;
  logic [5:0]    credit_q, credit_d;
  logic [7:0]    bottle_count_q, bottle_count_d;
  logic [7:0]    change_total_q, change_total_d;

  logic          pop;
  logic [CW-1:0] free;
  logic          acc_5, acc_10;
  logic [AW-1:0] wa_10;
  logic [6:0]    credit_sum;
  logic [8:0]    change_sum;
  logic [5:0]    credit_base;
  logic [3:0]    change_add;

  always_comb begin
    pop = (state_q == S_IDLE) && (cnt_q != '0);
    // A slot vacated by this cycle's pop is usable by this cycle's push.
    free = CW'(DEPTH) - cnt_q + CW'(pop);

    acc_5  = coin_5 && (free != '0);
    acc_10 = coin_10 && (free >= (coin_5 ? CW'(2) : CW'(1)));
    reject_d = (coin_5 && !acc_5) || (coin_10 && !acc_10);
    wa_10 = wr_ptr_q + AW'(acc_5);

    wr_ptr_d = wr_ptr_q + AW'(acc_5) + AW'(acc_10);
    rd_ptr_d = rd_ptr_q + AW'(pop);
    cnt_d    = cnt_q + CW'(acc_5) + CW'(acc_10) - CW'(pop);

    state_d = S_IDLE;
    in_d    = 2'b00;
    case (state_q)
      S_IDLE: if (pop) begin
        state_d = S_SEND;
        in_d    = mem_q[rd_ptr_q];
      end
      S_SEND:  state_d = S_GAP;
      S_GAP:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Bottle clears first, so a coin leaving in the same cycle starts the new credit.
    credit_base = bottle ? 6'd0 : credit_q;
    credit_sum  = {1'b0, credit_base};
    if (state_q == S_SEND)
      credit_sum = credit_sum + ((in_q == 2'b01) ? 7'd5 : 7'd10);
    credit_d = (credit_sum > 7'd63) ? 6'd63 : credit_sum[5:0];

    bottle_count_d = bottle_count_q + 8'(bottle);

    case (change)
      2'b01:   change_add = 4'd5;
      2'b10:   change_add = 4'd10;
      default: change_add = 4'd0;
    endcase
    change_sum     = {1'b0, change_total_q} + 9'(change_add);
    change_total_d = (change_sum > 9'd255) ? 8'd255 : change_sum[7:0];
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      if (acc_5)  mem_q[wr_ptr_q] <= 2'b01;
      if (acc_10) mem_q[wa_10]    <= 2'b10;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_q       <= '0;
      wr_ptr_q       <= '0;
      cnt_q          <= '0;
      state_q        <= S_IDLE;
      in_q           <= 2'b00;
      reject_q       <= 1'b0;
      credit_q       <= '0;
      bottle_count_q <= '0;
      change_total_q <= '0;
    end else begin
      rd_ptr_q       <= rd_ptr_d;
      wr_ptr_q       <= wr_ptr_d;
      cnt_q          <= cnt_d;
      state_q        <= state_d;
      in_q           <= in_d;
      reject_q       <= reject_d;
      credit_q       <= credit_d;
      bottle_count_q <= bottle_count_d;
      change_total_q <= change_total_d;
    end
  end

  assign in           = in_q;
  assign full         = (cnt_q == CW'(DEPTH));
  assign reject       = reject_q;
  assign credit       = credit_q;
  assign bottle_count = bottle_count_q;
  assign change_total = change_total_q;

endmodule

// File: tb/tb_coin_feeder_20.sv
// Bench for coin_feeder_20: directed scenarios with literal expectations, then
// random traffic checked every cycle against a queue-and-timing reference model.
module tb_coin_feeder_20;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       reset, coin_5, coin_10, bottle;
  logic [1:0] change;
  logic [1:0] in;
  logic       full, reject;
  logic [5:0] credit;
  logic [7:0] bottle_count, change_total;

  int errs = 0;
  int chks = 0;

  always #5 clk = ~clk;

  coin_feeder_20 #(.DEPTH(DEPTH), .PRICE(20)) dut (
    .clk(clk), .reset(reset), .coin_5(coin_5), .coin_10(coin_10),
    .bottle(bottle), .change(change), .in(in), .full(full), .reject(reject),
    .credit(credit), .bottle_count(bottle_count), .change_total(change_total)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    chks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a queue of codes; a coin may leave at most once every 3 edges,
  // shows on in for the cycle after it leaves, and is credited one edge after that.
  int mq[$];
  int cyc = 0, last_pop = -10, send_val = 0;
  int m_in = 0, m_rej = 0, m_credit = 0, m_bc = 0, m_ct = 0;
  int m_free, m_pv;
  bit m_valid = 0;

  always @(posedge clk) begin
    cyc++;
    if (reset) begin
      mq.delete();
      last_pop = cyc - 10; send_val = 0;
      m_in = 0; m_rej = 0; m_credit = 0; m_bc = 0; m_ct = 0;
      m_valid = 1;
    end else begin
      if (bottle) m_credit = 0;
      if (send_val != 0) m_credit = (m_credit + send_val > 63) ? 63 : m_credit + send_val;
      if (bottle) m_bc = (m_bc + 1) % 256;
      if (change == 2'b01) m_ct = (m_ct + 5 > 255) ? 255 : m_ct + 5;
      if (change == 2'b10) m_ct = (m_ct + 10 > 255) ? 255 : m_ct + 10;
      m_in = 0; send_val = 0;
      if (mq.size() > 0 && cyc >= last_pop + 3) begin
        m_pv = mq.pop_front();
        m_in = m_pv;
        send_val = (m_pv == 1) ? 5 : 10;
        last_pop = cyc;
      end
      m_free = DEPTH - mq.size();
      m_rej = 0;
      if (coin_5) begin
        if (m_free > 0) begin mq.push_back(1); m_free--; end else m_rej = 1;
      end
      if (coin_10) begin
        if (m_free > 0) begin mq.push_back(2); m_free--; end else m_rej = 1;
      end
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      chk("model_in", 32'(in), 32'(m_in));
      chk("model_full", 32'(full), 32'(mq.size() == DEPTH));
      chk("model_reject", 32'(reject), 32'(m_rej));
      chk("model_credit", 32'(credit), 32'(m_credit));
      chk("model_bottles", 32'(bottle_count), 32'(m_bc));
      chk("model_change", 32'(change_total), 32'(m_ct));
    end
  end

  // Called at a falling edge: drive inputs, return at the next falling edge.
  task automatic step(input logic c5, input logic c10, input logic b,
                      input logic [1:0] ch, input logic r);
    coin_5 = c5; coin_10 = c10; bottle = b; change = ch; reset = r;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 2'b00, 0);
  endtask

  initial begin
    int codes, rejs;
    reset = 1; coin_5 = 0; coin_10 = 0; bottle = 0; change = 2'b00;
    @(negedge clk);

    // Reset state, single coin_10 latency
    step(0, 0, 0, 2'b00, 1);
    chk("rst_in", 32'(in), 0);
    chk("rst_full", 32'(full), 0);
    chk("rst_credit", 32'(credit), 0);
    chk("rst_bottles", 32'(bottle_count), 0);
    chk("rst_change", 32'(change_total), 0);
    step(0, 1, 0, 2'b00, 0);
    chk("c10_in_early", 32'(in), 0);
    idle(1);
    chk("c10_in", 32'(in), 2);
    idle(1);
    chk("c10_in_after", 32'(in), 0);
    chk("c10_credit", 32'(credit), 10);
    chk("c10_model_credit", 32'(m_credit), 10);

    // Simultaneous coins: 01,00,00,10
    step(0, 0, 0, 2'b00, 1);
    step(1, 1, 0, 2'b00, 0);
    idle(1); chk("pair_in0", 32'(in), 1);
    idle(1); chk("pair_in1", 32'(in), 0);
    idle(1); chk("pair_in2", 32'(in), 0);
    idle(1); chk("pair_in3", 32'(in), 2);
    idle(1); chk("pair_credit", 32'(credit), 15);

    // Six coins in three cycles: only the sixth is refused
    step(0, 0, 0, 2'b00, 1);
    codes = 0; rejs = 0;
    for (int i = 0; i < 3; i++) begin
      step(1, 1, 0, 2'b00, 0);
      if (in != 0) codes++;
      if (reject) rejs++;
    end
    chk("six_reject", 32'(reject), 1);
    chk("six_full", 32'(full), 1);
    for (int i = 0; i < 20; i++) begin
      idle(1);
      if (in != 0) codes++;
      if (reject) rejs++;
    end
    chk("six_codes", 32'(codes), 5);
    chk("six_rejects", 32'(rejs), 1);

    // Credit 20, then bottle with change=01
    step(0, 0, 0, 2'b00, 1);
    step(0, 1, 0, 2'b00, 0);
    step(0, 1, 0, 2'b00, 0);
    idle(8);
    chk("bottle_pre_credit", 32'(credit), 20);
    step(0, 0, 1, 2'b01, 0);
    chk("bottle_credit", 32'(credit), 0);
    chk("bottle_count", 32'(bottle_count), 1);
    chk("bottle_change", 32'(change_total), 5);
    chk("bottle_model_ct", 32'(m_ct), 5);

    // Reset during SEND with three entries queued
    step(0, 0, 0, 2'b00, 1);
    step(1, 1, 0, 2'b00, 0);
    step(1, 1, 0, 2'b00, 0);
    chk("rsend_in_pre", 32'(in), 1);
    step(0, 0, 0, 2'b00, 1);
    chk("rsend_in", 32'(in), 0);
    chk("rsend_full", 32'(full), 0);
    chk("rsend_credit", 32'(credit), 0);
    codes = 0;
    for (int i = 0; i < 10; i++) begin
      idle(1);
      if (in != 0) codes++;
    end
    chk("rsend_codes", 32'(codes), 0);

    // change=11 is never counted
    for (int i = 0; i < 10; i++) step(0, 0, 0, 2'b11, 0);
    chk("chg11_total", 32'(change_total), 0);

    // Random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
           $urandom_range(0, 29) == 0,
           ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00,
           $urandom_range(0, 299) == 0);
    end
    idle(2);

    $display("Result: errors=%0d of %0d checks", errs, chks);
    $finish;
  end
endmodule

// File: doc/coin_feeder_20.md
COIN_FEEDER_20 -- requirements
Module: coin_feeder_20

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning coin queue depth in entries (power of two, 2..16).
REQ-002 SHALL have parameter PRICE, default 20, meaning product price in cents.
REQ-003 SHALL have port clk  input  1  system clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port coin_5  input  1  single-cycle pulse, a 5-cent coin was inserted.
REQ-006 SHALL have port coin_10  input  1  single-cycle pulse, a 10-cent coin was inserted.
REQ-007 SHALL have port bottle  input  1  vending machine dispense pulse.
REQ-008 SHALL have port change  input  2  vending machine change code: 00 none, 01 five, 10 ten, 11 ignored.
REQ-009 SHALL have port in  output  2  coin code to the vending machine: 00 idle, 01 five, 10 ten; 11 never driven.
REQ-010 SHALL have port full  output  1  queue holds DEPTH entries.
REQ-011 SHALL have port reject  output  1  one-cycle pulse, an arriving coin was refused.
REQ-012 SHALL have port credit  output  6  cents forwarded to the machine since the last bottle.
REQ-013 SHALL have port bottle_count  output  8  bottles dispensed since reset.
REQ-014 SHALL have port change_total  output  8  cents of change returned since reset.

Function
REQ-015 SHALL enqueue each coin pulse as its 2-bit code in a FIFO of DEPTH entries.
REQ-016 SHALL, when coin_5 and coin_10 arrive in the same cycle, enqueue 01 before 10 if two slots are free.
REQ-017 SHALL, in that case with one slot free, enqueue only 01 and pulse reject for the 10.
REQ-018 SHALL, with no slot free, enqueue nothing and pulse reject for one cycle; a coin is never lost silently.
REQ-019 SHALL compute free space including an entry dequeued in the same cycle (simultaneous push and pop on a full queue accepts the push).
REQ-020 SHALL use a three-state sender FSM: IDLE, SEND, GAP.
REQ-021 IDLE: in=00; if the queue is non-empty, pop the head and go to SEND next cycle.
REQ-022 SEND: in=popped code for exactly one cycle; credit+=5 or 10 (saturating at 63); go to GAP.
REQ-023 GAP: in=00 for exactly one cycle; go to IDLE. The minimum coin-to-coin spacing on in is therefore 3 cycles.
REQ-024 SHALL give latency from coin pulse at edge N (empty queue, FSM in IDLE) to in valid during cycle N+2.
REQ-025 SHALL, on bottle=1, clear credit to 0 and increment bottle_count (wrap at 255); bottle in the same cycle as SEND clears credit, then adds that coin's value.
REQ-026 SHALL, on change=01 or 10, add 5 or 10 to change_total (saturating at 255), independent of bottle.
REQ-027 SHALL assert full combinationally from the occupancy count; the queue pointers wrap modulo DEPTH.
REQ-028 SHALL ignore change=11 and never count it.

Reset
REQ-029 SHALL, on reset=1 at a clock edge, empty the queue, enter IDLE, and zero in, reject, credit, bottle_count, and change_total; full=0.
REQ-030 SHALL give reset priority over coin, bottle, and change inputs in the same cycle; a coin pulsed with reset is dropped without reject.
REQ-031 SHALL, on reset asserted during SEND, drive in=00 on the next cycle; the coin in flight is discarded.

Verification
REQ-032 Reset, then pulse coin_10 once -> in=10 for one cycle two cycles later, then 00; credit=10.
REQ-033 Pulse coin_5 and coin_10 together -> in sequence 01,00,00,10; credit=15.
REQ-034 Pulse 6 coins back-to-back with DEPTH=4 -> the 6th coin pulses reject; one of the 6 is popped first, so only the 6th is refused; exactly 5 codes appear on in.
REQ-035 Credit reaches 20, then bottle=1 and change=01 in the same cycle -> credit=0, bottle_count=1, change_total=5.
REQ-036 Assert reset during SEND with 3 entries queued -> in=00, full=0, credit=0 next cycle; no further codes emitted.
REQ-037 Drive change=11 for 10 cycles -> change_total stays 0.
